// File: rtl/pixel_burst_ctrl.sv
// pixel_burst_ctrl
// SRAM pixel burst engine. On a start pulse it reads rd_count RGB pixels from
// SRAM (converted to greyscale or passed through) into rd_buf_o. It then writes
// wr_count pixels from wr_buf_i back to SRAM. Every access holds its address and
// strobe for wait_cycles+1 cycles.
//
// Ports:
//   clk_i, n_rst_i         clock, asynchronous active-low reset
//   start_i                begin an operation (sampled only while idle)
//   rd_base_i, wr_base_i   first read / write address
//   rd_count_i, wr_count_i pixels to read / write (0 skips that phase)
//   wait_cycles_i          extra cycles per SRAM access
//   gray_mode_i            1 = greyscale convert, 0 = pass low pixel bits
//   wr_buf_i               pixels to write, index 0 in the low bits
//   rd_buf_o               pixels read, index 0 in the low bits
//   busy_o, done_o, err_o  status: not idle / completion pulse / rejected start
//   address_o, w_data_o    SRAM address and write data
//   r_data_i               SRAM read data {R,G,B}
//   read_enable_o          SRAM read strobe
//   write_enable_o         SRAM write strobe
module pixel_burst_ctrl #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned MAX_PIX = 20,
    parameter int unsigned CNT_W   = $clog2(MAX_PIX + 1),
    parameter int unsigned WAIT_W  = 4
) (
    input  logic                     clk_i,
    input  logic                     n_rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        rd_base_i,
    input  logic [ADDR_W-1:0]        wr_base_i,
    input  logic [CNT_W-1:0]         rd_count_i,
    input  logic [CNT_W-1:0]         wr_count_i,
    input  logic [WAIT_W-1:0]        wait_cycles_i,
    input  logic                     gray_mode_i,
    input  logic [MAX_PIX*PIX_W-1:0] wr_buf_i,
    output logic [MAX_PIX*PIX_W-1:0] rd_buf_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [ADDR_W-1:0]        address_o,
    output logic [23:0]              w_data_o,
    input  logic [23:0]              r_data_i,
    output logic                     read_enable_o,
    output logic                     write_enable_o
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StGap,
        StWrite,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        rd_base_q, rd_base_d;
    logic [ADDR_W-1:0]        wr_base_q, wr_base_d;
    logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
    logic [WAIT_W-1:0]        wait_q, wait_d;
    logic                     gray_q, gray_d;
    logic [CNT_W-1:0]         pix_q, pix_d;
    logic [WAIT_W-1:0]        wcnt_q, wcnt_d;
    logic                     err_q, err_d;
    logic [MAX_PIX*PIX_W-1:0] rd_buf_q, rd_buf_d;

    logic                     last_beat;
    logic                     start_bad;
    logic [9:0]               rgb_sum;
    logic [9:0]               grey;
    logic [PIX_W-1:0]         pix_in;
    logic [PIX_W-1:0]         wr_pix;
    logic [7:0]               wr_pix8;

    // Greyscale approximation of (R+G+B)/3 by a sum of shifted copies of the sum.
    always_comb begin
        rgb_sum = 10'(r_data_i[23:16]) + 10'(r_data_i[15:8]) + 10'(r_data_i[7:0]);
        grey    = (rgb_sum >> 2) + (rgb_sum >> 4) + (rgb_sum >> 6) + (rgb_sum >> 8);
        pix_in  = gray_q ? PIX_W'(grey) : r_data_i[PIX_W-1:0];
        wr_pix  = wr_buf_i[int'(pix_q)*PIX_W +: PIX_W];
        wr_pix8 = 8'(wr_pix);
    end

    assign last_beat = (wcnt_q == wait_q);
    assign start_bad = (rd_count_i > CNT_W'(MAX_PIX)) || (wr_count_i > CNT_W'(MAX_PIX));

    always_comb begin
        state_d   = state_q;
        rd_base_d = rd_base_q;
        wr_base_d = wr_base_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        wait_d    = wait_q;
        gray_d    = gray_q;
        pix_d     = pix_q;
        wcnt_d    = wcnt_q;
        err_d     = 1'b0;
        rd_buf_d  = rd_buf_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        rd_base_d = rd_base_i;
                        wr_base_d = wr_base_i;
                        rd_cnt_d  = rd_count_i;
                        wr_cnt_d  = wr_count_i;
                        wait_d    = wait_cycles_i;
                        gray_d    = gray_mode_i;
                        pix_d     = '0;
                        wcnt_d    = '0;
                        if (rd_count_i != '0) begin
                            state_d = StRead;
                        end else if (wr_count_i != '0) begin
                            state_d = StWrite;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StRead: begin
                if (last_beat) begin
                    wcnt_d = '0;
                    rd_buf_d[int'(pix_q)*PIX_W +: PIX_W] = pix_in;
                    if (pix_q == rd_cnt_q - CNT_W'(1)) begin
                        pix_d   = '0;
                        state_d = (wr_cnt_q != '0) ? StGap : StDone;
                    end else begin
                        pix_d = pix_q + CNT_W'(1);
                    end
                end else begin
                    wcnt_d = wcnt_q + WAIT_W'(1);
                end
            end
            StGap: begin
                state_d = StWrite;
            end
            StWrite: begin
                if (last_beat) begin
                    wcnt_d = '0;
                    if (pix_q == wr_cnt_q - CNT_W'(1)) begin
                        pix_d   = '0;
                        state_d = StDone;
                    end else begin
                        pix_d = pix_q + CNT_W'(1);
                    end
                end else begin
                    wcnt_d = wcnt_q + WAIT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q   <= StIdle;
            rd_base_q <= '0;
            wr_base_q <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            wait_q    <= '0;
            gray_q    <= 1'b0;
            pix_q     <= '0;
            wcnt_q    <= '0;
            err_q     <= 1'b0;
            rd_buf_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_base_q <= rd_base_d;
            wr_base_q <= wr_base_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wait_q    <= wait_d;
            gray_q    <= gray_d;
            pix_q     <= pix_d;
            wcnt_q    <= wcnt_d;
            err_q     <= err_d;
            rd_buf_q  <= rd_buf_d;
        end
    end

    // Outputs decode from the registered state only; idle bus is driven to zero.
    always_comb begin
        busy_o         = (state_q != StIdle);
        done_o         = (state_q == StDone);
        err_o          = err_q;
        read_enable_o  = (state_q == StRead);
        write_enable_o = (state_q == StWrite);
        address_o      = '0;
        w_data_o       = '0;
        if (state_q == StRead) begin
            address_o = rd_base_q + ADDR_W'(pix_q);
        end else if (state_q == StWrite) begin
            address_o = wr_base_q + ADDR_W'(pix_q);
            w_data_o  = {3{wr_pix8}};
        end
    end

    assign rd_buf_o = rd_buf_q;

endmodule

// File: tb/tb_pixel_burst_ctrl.sv
// Randomised self-checking bench for pixel_burst_ctrl. A behavioural model
// expands each operation into the expected per-cycle bus trace and the
// expected rd_buf contents, which are compared against the DUT.
module tb_pixel_burst_ctrl;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned MAX_PIX = 20;
    localparam int unsigned CNT_W   = $clog2(MAX_PIX + 1);
    localparam int unsigned WAIT_W  = 4;
    localparam int unsigned OBS_W   = 5 + ADDR_W + 24;

    logic                     clk;
    logic                     n_rst;
    logic                     start;
    logic [ADDR_W-1:0]        rd_base, wr_base;
    logic [CNT_W-1:0]         rd_count, wr_count;
    logic [WAIT_W-1:0]        wait_cycles;
    logic                     gray_mode;
    logic [MAX_PIX*PIX_W-1:0] wr_buf;
    logic [MAX_PIX*PIX_W-1:0] rd_buf;
    logic                     busy, done, err;
    logic [ADDR_W-1:0]        address;
    logic [23:0]              w_data;
    logic [23:0]              r_data;
    logic                     read_enable, write_enable;

    // SRAM stand-in: either a constant word or a salted function of the address.
    logic                     const_en;
    logic [23:0]              const_val;
    logic [23:0]              salt;

    logic [PIX_W-1:0]         wpix    [MAX_PIX];
    logic [PIX_W-1:0]         exp_buf [MAX_PIX];

    int total;
    int bad;

    pixel_burst_ctrl #(
        .ADDR_W (ADDR_W),
        .PIX_W  (PIX_W),
        .MAX_PIX(MAX_PIX),
        .CNT_W  (CNT_W),
        .WAIT_W (WAIT_W)
    ) u_dut (
        .clk_i         (clk),
        .n_rst_i       (n_rst),
        .start_i       (start),
        .rd_base_i     (rd_base),
        .wr_base_i     (wr_base),
        .rd_count_i    (rd_count),
        .wr_count_i    (wr_count),
        .wait_cycles_i (wait_cycles),
        .gray_mode_i   (gray_mode),
        .wr_buf_i      (wr_buf),
        .rd_buf_o      (rd_buf),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .address_o     (address),
        .w_data_o      (w_data),
        .r_data_i      (r_data),
        .read_enable_o (read_enable),
        .write_enable_o(write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] sram_val(input logic [ADDR_W-1:0] a);
        if (const_en) return const_val;
        return {a[7:0] ^ salt[7:0], a[15:8] ^ salt[15:8], a[7:0] + salt[23:16]};
    endfunction

    always_comb r_data = sram_val(address);

    function automatic logic [PIX_W-1:0] model_pix(input logic [23:0] d, input bit g);
        int s;
        int v;
        s = int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
        v = s / 4 + s / 16 + s / 64 + s / 256;
        if (g) return PIX_W'(v % (1 << PIX_W));
        return d[PIX_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [OBS_W-1:0] obs();
        return {busy, read_enable, write_enable, done, err, address, w_data};
    endfunction

    task automatic pack_wr();
        for (int i = 0; i < MAX_PIX; i++) wr_buf[i*PIX_W +: PIX_W] = wpix[i];
    endtask

    task automatic check_rdbuf(input string tag);
        for (int i = 0; i < MAX_PIX; i++)
            check($sformatf("%s_rdbuf%0d", tag, i), 64'(rd_buf[i*PIX_W +: PIX_W]),
                  64'(exp_buf[i]));
    endtask

    // Runs one operation and checks every cycle of it. abort_at >= 0 asserts the
    // reset asynchronously just after that trace entry is checked.
    task automatic run_op(input string tag, input logic [15:0] rb, input logic [15:0] wb,
                          input int rc, input int wc, input int w, input bit g,
                          input bit noisy, input int abort_at);
        logic [OBS_W-1:0] q[$];
        logic [PIX_W-1:0] nb [MAX_PIX];
        logic [15:0]      a;
        logic [7:0]       p8;
        bit               ok;

        ok = (rc <= int'(MAX_PIX)) && (wc <= int'(MAX_PIX));
        for (int i = 0; i < MAX_PIX; i++) nb[i] = exp_buf[i];
        if (!ok) begin
            q.push_back({5'b00001, 16'h0, 24'h0});
        end else begin
            for (int i = 0; i < rc; i++) begin
                a = rb + 16'(i);
                nb[i] = model_pix(sram_val(a), g);
                for (int k = 0; k <= w; k++) q.push_back({5'b11000, a, 24'h0});
            end
            if (rc > 0 && wc > 0) q.push_back({5'b10000, 16'h0, 24'h0});
            for (int i = 0; i < wc; i++) begin
                a  = wb + 16'(i);
                p8 = 8'(wpix[i]);
                for (int k = 0; k <= w; k++) q.push_back({5'b10100, a, {3{p8}}});
            end
            q.push_back({5'b10010, 16'h0, 24'h0});
        end
        q.push_back('0);

        @(negedge clk);
        rd_base     = rb;
        wr_base     = wb;
        rd_count    = CNT_W'(rc);
        wr_count    = CNT_W'(wc);
        wait_cycles = WAIT_W'(w);
        gray_mode   = g;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (noisy) begin
            rd_base     = 16'($urandom);
            wr_base     = 16'($urandom);
            rd_count    = CNT_W'($urandom);
            wr_count    = CNT_W'($urandom);
            wait_cycles = WAIT_W'($urandom);
            gray_mode   = 1'($urandom);
        end
        for (int j = 0; j < q.size(); j++) begin
            @(negedge clk);
            check($sformatf("%s_cyc%0d", tag, j), 64'(obs()), 64'(q[j]));
            if (j == abort_at) begin
                #1;
                n_rst = 1'b0;
                #1;
                check({tag, "_rst_bus"}, 64'(obs()), 64'h0);
                for (int i = 0; i < MAX_PIX; i++) exp_buf[i] = '0;
                check_rdbuf({tag, "_rst"});
                start = 1'b0;
                @(negedge clk);
                n_rst = 1'b1;
                return;
            end
            // The DUT is guaranteed to ignore start only while it is busy.
            start = (noisy && q[j][OBS_W-1]) ? 1'($urandom) : 1'b0;
        end
        start = 1'b0;
        if (ok) for (int i = 0; i < MAX_PIX; i++) exp_buf[i] = nb[i];
        check_rdbuf(tag);
    endtask

    initial begin
        int rc;
        int wc;
        int w;
        total       = 0;
        bad         = 0;
        n_rst       = 1'b0;
        start       = 1'b0;
        rd_base     = '0;
        wr_base     = '0;
        rd_count    = '0;
        wr_count    = '0;
        wait_cycles = '0;
        gray_mode   = 1'b0;
        const_en    = 1'b0;
        const_val   = '0;
        salt        = 24'($urandom);
        for (int i = 0; i < MAX_PIX; i++) begin
            wpix[i]    = PIX_W'($urandom);
            exp_buf[i] = '0;
        end
        pack_wr();

        #12;
        check("reset_bus", 64'(obs()), 64'h0);
        check_rdbuf("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // All-white greyscale: 765 -> 191+47+11+2 = 251.
        const_en  = 1'b1;
        const_val = 24'hFFFFFF;
        run_op("white", 16'h0100, 16'h0200, 3, 2, 0, 1'b1, 1'b0, -1);
        check("white_px0", 64'(rd_buf[PIX_W-1:0]), 64'd251);

        const_val = 24'h102030;
        run_op("pass", 16'h0040, 16'h0000, 1, 0, 2, 1'b0, 1'b0, -1);
        check("pass_px0", 64'(rd_buf[PIX_W-1:0]), 64'h30);

        run_op("badrd", 16'h0001, 16'h0002, 21, 3, 1, 1'b1, 1'b0, -1);
        run_op("badwr", 16'h0001, 16'h0002, 2, 31, 0, 1'b1, 1'b0, -1);
        run_op("empty", 16'h0003, 16'h0004, 0, 0, 3, 1'b0, 1'b0, -1);

        const_en = 1'b0;
        wpix[0]  = 8'h5A;
        pack_wr();
        run_op("wrap", 16'hFFFF, 16'hFFFF, 2, 1, 1, 1'b1, 1'b1, -1);
        run_op("wronly", 16'h0000, 16'h1234, 0, 4, 2, 1'b0, 1'b1, -1);

        // Abort inside the write phase: 4*(1+1) read + gap + 2 write cycles.
        run_op("abort", 16'h0010, 16'h0020, 4, 6, 1, 1'b1, 1'b0, 11);
        run_op("after", 16'h0030, 16'h0040, 3, 2, 0, 1'b1, 1'b0, -1);

        for (int t = 0; t < 30; t++) begin
            salt = 24'($urandom);
            for (int i = 0; i < MAX_PIX; i++) wpix[i] = PIX_W'($urandom);
            pack_wr();
            rc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(21, 31))
                                              : int'($urandom_range(0, 20));
            wc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(21, 31))
                                              : int'($urandom_range(0, 20));
            w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                              : int'($urandom_range(0, 2));
            run_op($sformatf("rnd%0d", t), 16'($urandom), 16'($urandom), rc, wc, w,
                   1'($urandom), 1'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
